data_mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_lane_unit.sv | 56 +++++
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 tb/tb_data_mem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_unit.sv
// Lane extraction/extension for loads and read-merge for stores.
// Purely combinational; the illegal size encoding is folded into misalign_o.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_ld_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_val_o,
    output logic [31:0] st_word_o,
    output logic        misalign_o
);

    logic [4:0]  bit_ofs;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        ext_b;
    logic        ext_h;

    assign bit_ofs = {lane_i, 3'b000};
    assign byte_v  = 8'(word_i >> bit_ofs);
    assign half_v  = lane_i[1] ? word_i[31:16] : word_i[15:0];
    assign ext_b   = ~unsigned_ld_i & byte_v[7];
    assign ext_h   = ~unsigned_ld_i & half_v[15];

    // Select load value, merged store word and alignment check by access size
    always_comb begin
        ld_val_o   = word_i;
        st_word_o  = word_i;
        misalign_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                ld_val_o  = {{24{ext_b}}, byte_v};
                st_word_o = (word_i & ~(32'h0000_00ff << bit_ofs))
                          | ({24'd0, wdata_i[7:0]} << bit_ofs);
            end
            SZ_HALF: begin
                misalign_o = lane_i[0];
                ld_val_o   = {{16{ext_h}}, half_v};
                st_word_o  = lane_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                       : {word_i[31:16], wdata_i[15:0]};
            end
            SZ_WORD: begin
                misalign_o = (lane_i != 2'b00);
                ld_val_o   = word_i;
                st_word_o  = wdata_i;
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store in IDLE, waits WAIT_CYCLES,
// performs the access on the BUSY->RESP edge and pulses ready for one cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for en; request fields latched on acceptance
// ST_BUSY | wait-state countdown; access performed when counter is 0
// ST_RESP | ready=1 for one cycle, err/rdata valid
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        rw,
    input  logic [31:0] mem_addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        rw_q, rw_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [31:0]   word_rd;
    logic [31:0]   ld_val;
    logic [31:0]   st_word;
    logic          misalign;
    logic          range_err;
    logic          acc_err;
    logic          do_access;
    logic          do_write;

    assign idx       = addr_q[AW+1:2];
    assign word_rd   = mem[idx];
    assign range_err = ((addr_q >> (AW + 2)) != 32'd0);
    assign acc_err   = range_err | misalign;
    assign do_access = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign do_write  = do_access && (rw_q == RW_STORE) && !acc_err;

    mem_lane_unit u_lane (
        .word_i        (word_rd),
        .lane_i        (addr_q[1:0]),
        .size_i        (size_q),
        .unsigned_ld_i (uns_q),
        .wdata_i       (wdata_q),
        .ld_val_o      (ld_val),
        .st_word_o     (st_word),
        .misalign_o    (misalign)
    );

    // Next-state, counter, request latch and response computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rw_d    = rw_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    addr_d  = mem_addr;
                    wdata_d = wdata;
                    size_d  = size;
                    rw_d    = rw;
                    uns_d   = unsigned_ld;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d   = acc_err;
                    rdata_d = (acc_err || rw_q == RW_STORE) ? 32'd0 : ld_val;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= SZ_BYTE;
            rw_q    <= RW_LOAD;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= st_word;
        end
    end

    assign ready = (state_q == ST_RESP);
    assign busy  = (state_q != ST_IDLE);
    assign err   = ready & err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a byte-addressed reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rw          (rw),
        .mem_addr    (mem_addr),
        .wdata       (wdata),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .rdata       (rdata),
        .ready       (ready),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: memory as individual bytes, little-endian.
    logic [7:0]  mb [int unsigned];
    int          m_phase = -1;
    logic        m_rw, m_uns;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [31:0] m_rdata = 32'd0;
    logic        m_err = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;

    function automatic logic [7:0] rd_byte(input int unsigned a);
        if (mb.exists(a)) return mb[a];
        return 8'h00;
    endfunction

    function automatic void model_access();
        int unsigned nb;
        logic [31:0] v;
        m_err = (m_size == 2'b11)
             || (m_size == 2'b01 && m_addr[0])
             || (m_size == 2'b10 && m_addr[1:0] != 2'b00)
             || (m_addr >= 32'(4 * DEPTH));
        m_rdata = 32'd0;
        if (m_err) return;
        nb = 1 << m_size;
        if (m_rw) begin
            for (int unsigned i = 0; i < nb; i++)
                mb[m_addr + i] = 8'(m_wdata >> (8 * i));
        end else begin
            v = 32'd0;
            for (int unsigned i = 0; i < nb; i++)
                v = v | (32'(rd_byte(m_addr + i)) << (8 * i));
            if (nb == 1 && !m_uns && v[7])  v = v | 32'hFFFF_FF00;
            if (nb == 2 && !m_uns && v[15]) v = v | 32'hFFFF_0000;
            m_rdata = v;
        end
    endfunction

    // Model timeline: accept in idle, access WAITC+1 edges later, one response cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = -1;
        end else begin
            cyc++;
            if (m_phase < 0) begin
                if (en) begin
                    m_phase = 0;
                    m_rw = rw; m_addr = mem_addr; m_wdata = wdata;
                    m_size = size; m_uns = unsigned_ld;
                    acc_cyc = cyc;
                end
            end else begin
                m_phase++;
                if (m_phase == WAITC + 1) model_access();
                else if (m_phase > WAITC + 1) m_phase = -1;
            end
        end
    end

    int          ready_cnt = 0;
    int          ready_cyc = 0;
    logic [31:0] cap_rdata = 32'd0;
    logic        cap_err = 1'b0;

    // Per-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        logic exp_busy, exp_ready;
        exp_busy  = (m_phase >= 0);
        exp_ready = (m_phase == WAITC + 1);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("ready", 32'(ready), 32'(exp_ready));
        if (exp_ready) begin
            chk("err", 32'(err), 32'(m_err));
            chk("rdata", rdata, m_rdata);
        end else begin
            chk("err_idle", 32'(err), 32'd0);
        end
        if (ready) begin
            ready_cnt++;
            cap_rdata = rdata;
            cap_err   = err;
            ready_cyc = cyc;
        end
    end

    task automatic req(input logic r, input logic [31:0] a, input logic [31:0] w,
                       input logic [1:0] s, input logic u,
                       output logic [31:0] rd, output logic e);
        int n0;
        int k;
        n0 = ready_cnt;
        @(posedge clk); #1;
        en = 1'b1; rw = r; mem_addr = a; wdata = w; size = s; unsigned_ld = u;
        @(posedge clk); #1;
        en = 1'b0;
        k = 0;
        while (ready_cnt == n0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        if (ready_cnt == n0) begin
            total++; bad++;
            $display("FAIL req_timeout: no ready for addr %08h", a);
        end
        rd = cap_rdata;
        e  = cap_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          n0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, e);
        chk("st_w_err", 32'(e), 32'd0);
        chk("st_w_rdata", rd, 32'd0);
        chk("latency", 32'(ready_cyc - acc_cyc), 32'd2);
        req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, e);
        chk("ld_w_10", rd, 32'hDEADBEEF);

        req(1'b1, 32'h12, 32'h5A, 2'b00, 1'b0, rd, e);
        req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, e);
        chk("ld_w_merged", rd, 32'hDE5ABEEF);
        req(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, e);
        chk("ld_b_signed", rd, 32'hFFFFFFDE);
        req(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, e);
        chk("ld_b_unsigned", rd, 32'h000000DE);
        req(1'b0, 32'h12, 32'h0, 2'b00, 1'b0, rd, e);
        chk("ld_b_pos", rd, 32'h0000005A);
        req(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, rd, e);
        chk("ld_h_lo_signed", rd, 32'hFFFFBEEF);

        req(1'b1, 32'h14, 32'h0, 2'b10, 1'b0, rd, e);
        req(1'b1, 32'h16, 32'h8001, 2'b01, 1'b0, rd, e);
        req(1'b0, 32'h16, 32'h0, 2'b01, 1'b0, rd, e);
        chk("ld_h_signed", rd, 32'hFFFF8001);
        req(1'b0, 32'h16, 32'h0, 2'b01, 1'b1, rd, e);
        chk("ld_h_unsigned", rd, 32'h00008001);
        req(1'b0, 32'h15, 32'h0, 2'b01, 1'b0, rd, e);
        chk("ld_h_mis_err", 32'(e), 32'd1);
        chk("ld_h_mis_rdata", rd, 32'd0);
        req(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, rd, e);
        chk("ld_w_14", rd, 32'h80010000);

        req(1'b1, 32'h11, 32'hCAFEF00D, 2'b10, 1'b0, rd, e);
        chk("st_w_mis_err", 32'(e), 32'd1);
        req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, e);
        chk("ld_w_unchanged", rd, 32'hDE5ABEEF);
        req(1'b0, 32'(4 * DEPTH), 32'h0, 2'b10, 1'b0, rd, e);
        chk("ld_range_err", 32'(e), 32'd1);
        chk("ld_range_rdata", rd, 32'd0);
        req(1'b1, 32'(4 * DEPTH), 32'hFF, 2'b00, 1'b0, rd, e);
        chk("st_range_err", 32'(e), 32'd1);
        req(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, e);
        chk("size11_err", 32'(e), 32'd1);
        req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, e);
        chk("ld_w_after_err", rd, 32'hDE5ABEEF);

        // Reset in the middle of a store
        req(1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, rd, e);
        n0 = ready_cnt;
        @(posedge clk); #1;
        en = 1'b1; rw = 1'b1; mem_addr = 32'h20; wdata = 32'h12345678; size = 2'b10;
        @(posedge clk); #1;
        en = 1'b0;
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("busy_in_rst", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        chk("no_ready_after_rst", 32'(ready_cnt - n0), 32'd0);
        req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, e);
        chk("ld_w_20_kept", rd, 32'h11111111);

        // en held high: one acceptance per idle window
        n0 = ready_cnt;
        @(posedge clk); #1;
        en = 1'b1; rw = 1'b0; mem_addr = 32'h10; size = 2'b10; unsigned_ld = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        chk("held_en_pulses", 32'(ready_cnt - n0), 32'd2);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
